// File: rtl/aes_mix_pkg.sv
// Shared types and constants for the sequential AES (Inv)MixColumns column engine.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package aes_mix_pkg;

   // Controller states: waiting for a column, accumulating 16 products, holding the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned COL_W = 32;

   // Coefficient rows packed with coef[0] in the top byte.
   localparam logic [COL_W-1:0] FWD_COEF = 32'h02_03_01_01;
   localparam logic [COL_W-1:0] INV_COEF = 32'h0E_0B_0D_09;

   // Pick coef[k] from the forward or inverse row.
   function automatic logic [7:0] coef_sel(input logic inv, input logic [1:0] k);
      logic [COL_W-1:0] row;
      logic [7:0]       b;
      row = inv ? INV_COEF : FWD_COEF;
      case (k)
         2'd0:    b = row[31:24];
         2'd1:    b = row[23:16];
         2'd2:    b = row[15:8];
         default: b = row[7:0];
      endcase
      return b;
   endfunction

   // Byte i of a column, byte 0 being the most significant.
   function automatic logic [7:0] col_byte(input logic [COL_W-1:0] w, input logic [1:0] i);
      logic [7:0] b;
      case (i)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/mix_column_seq_if.sv
// Column request/response bundle between a producer/consumer and mix_column_seq.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the input column and the result column.
interface mix_column_seq_if;
   import aes_mix_pkg::*;

   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [COL_W-1:0] col_in;
   logic             inv;
   logic             out_valid;
   logic             out_ready;
   logic [COL_W-1:0] col_out;
   logic             busy;

   // Producer/consumer side.
   modport master (
      output clear, in_valid, col_in, inv, out_ready,
      input  in_ready, out_valid, col_out, busy
   );

   // Engine side.
   modport slave (
      input  clear, in_valid, col_in, inv, out_ready,
      output in_ready, out_valid, col_out, busy
   );

endinterface

// File: rtl/ff_mult.sv
// Combinational GF(2^NUM_BITS) multiplier reducing by the polynomial x^NUM_BITS + POLY.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the operands.
module ff_mult #(
   parameter int unsigned NUM_BITS = 8,
   parameter int unsigned POLY     = 'h1B
) (
   input  logic [NUM_BITS-1:0] a,
   input  logic [NUM_BITS-1:0] b,
   output logic [NUM_BITS-1:0] p
);

   localparam logic [NUM_BITS-1:0] RED = POLY[NUM_BITS-1:0];

   // Shift-and-add: x is doubled (xtime) once per bit of y.
   function automatic logic [NUM_BITS-1:0] gf_mul(input logic [NUM_BITS-1:0] x,
                                                  input logic [NUM_BITS-1:0] y);
      logic [NUM_BITS-1:0] acc;
      logic [NUM_BITS-1:0] sh;
      acc = '0;
      sh  = x;
      for (int i = 0; i < int'(NUM_BITS); i++) begin
         if (y[i]) acc = acc ^ sh;
         sh = {sh[NUM_BITS-2:0], 1'b0} ^ (sh[NUM_BITS-1] ? RED : '0);
      end
      return acc;
   endfunction

   assign p = gf_mul(a, b);

endmodule

// File: rtl/mix_column_seq.sv
// Sequential AES MixColumns/InvMixColumns on one 32-bit column using a single GF(2^8) multiplier.
// Latency: out_valid rises after the 16th clock edge following accept; accepts at most every 18 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, clear aborts at any time.
module mix_column_seq
   import aes_mix_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   mix_column_seq_if.slave io
);

   state_t           state_q;
   state_t           state_nxt;
   logic [3:0]       cnt_q;
   logic [COL_W-1:0] col_q;
   logic [COL_W-1:0] res_q;
   logic [COL_W-1:0] res_nxt;
   logic             inv_q;

   logic             accept;
   logic             mult_en;
   logic             in_ready;
   logic             out_valid;
   logic             busy;
   logic [1:0]       row;
   logic [1:0]       col_idx;
   logic [1:0]       k;
   logic [7:0]       coef;
   logic [7:0]       a_c;
   logic [7:0]       prod;

   // clear wins over an incoming column, so it gates the accept.
   assign accept  = io.in_valid & in_ready & ~io.clear;

   // cnt walks the 4x4 coefficient matrix row-major: row = result byte, col_idx = input byte.
   assign row     = cnt_q[3:2];
   assign col_idx = cnt_q[1:0];
   assign k       = col_idx - row;   // 2-bit wrap gives (c - r) mod 4
   assign coef    = coef_sel(inv_q, k);
   assign a_c     = col_byte(col_q, col_idx);

   ff_mult #(
      .NUM_BITS (8)
   ) u_mult (
      .a (coef),
      .b (a_c),
      .p (prod)
   );

   // Fold this cycle's product into the result byte selected by row.
   always_comb begin
      res_nxt = res_q;
      case (row)
         2'd0:    res_nxt[31:24] = res_q[31:24] ^ prod;
         2'd1:    res_nxt[23:16] = res_q[23:16] ^ prod;
         2'd2:    res_nxt[15:8]  = res_q[15:8]  ^ prod;
         default: res_nxt[7:0]   = res_q[7:0]   ^ prod;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_nxt;
   end

   // Next-state logic; clear overrides every other transition.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (io.in_valid)    state_nxt = MULT;
         MULT:    if (cnt_q == 4'd15) state_nxt = DONE;
         DONE:    if (io.out_ready)   state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
      if (io.clear) state_nxt = IDLE;
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      mult_en   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         MULT:    mult_en   = 1'b1;
         DONE:    out_valid = 1'b1;
         default: begin
            in_ready = 1'b0;
            busy     = 1'b1;
         end
      endcase
   end

   // Operand latch, accumulator and product counter; cnt wraps 15->0 on the MULT->DONE edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q <= '0;
         inv_q <= 1'b0;
         res_q <= '0;
         cnt_q <= '0;
      end else if (io.clear) begin
         res_q <= '0;
         cnt_q <= '0;
      end else if (accept) begin
         col_q <= io.col_in;
         inv_q <= io.inv;
         res_q <= '0;
         cnt_q <= '0;
      end else if (mult_en) begin
         res_q <= res_nxt;
         cnt_q <= cnt_q + 4'd1;
      end
   end

   assign io.in_ready  = in_ready;
   assign io.out_valid = out_valid;
   assign io.busy      = busy;
   assign io.col_out   = res_q;

endmodule

// File: tb/tb_mix_column_seq.sv
// Directed self-checking bench for mix_column_seq: known AES column vectors, latency, hold, abort, reset.
// Latency: checks the 16-edge accept-to-out_valid timing on every column.
// Backpressure: exercises early and late out_ready, long stalls and clear/rst mid-operation.
module tb_mix_column_seq;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mix_column_seq_if bus ();

   mix_column_seq dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one column, verify latency and result, then finish the output handshake.
   task automatic run_col(input string tag, input logic [31:0] col, input logic inv_b,
                          input logic [31:0] exp, input logic early, input int hold);
      chk({tag, "/in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid  = 1'b1;
      bus.col_in    = col;
      bus.inv       = inv_b;
      bus.out_ready = early;
      @(negedge clk);                       // accept edge E0 has passed
      bus.in_valid = 1'b0;
      bus.col_in   = ~col;                  // must not disturb the latched operand
      bus.inv      = ~inv_b;
      chk({tag, "/busy"}, {30'd0, bus.busy, bus.in_ready}, 32'd2);
      repeat (15) @(negedge clk);           // after E15
      chk({tag, "/early_valid"}, {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);                       // after E16
      chk({tag, "/valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "/col_out"}, bus.col_out, exp);
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = (h >= 5 && h < 8);
         bus.col_in   = $urandom;
         @(negedge clk);
         chk({tag, "/hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
         chk({tag, "/hold_col"}, bus.col_out, exp);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);                       // handshake edge
      bus.out_ready = 1'b0;
      chk({tag, "/after_hs"}, {29'd0, bus.out_valid, bus.busy, bus.in_ready}, 32'd1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst           = 1'b1;
      bus.clear     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.col_in    = '0;
      bus.inv       = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      chk("reset_ctl", {29'd0, bus.out_valid, bus.busy, bus.in_ready}, 32'd1);
      chk("reset_col", bus.col_out, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Known AES column vectors in both directions.
      run_col("fwd_db13",  32'hDB135345, 1'b0, 32'h8E4DA1BC, 1'b0, 0);
      run_col("inv_8e4d",  32'h8E4DA1BC, 1'b1, 32'hDB135345, 1'b1, 0);
      run_col("inv_9fdc",  32'h9FDC589D, 1'b1, 32'hF20A225C, 1'b0, 0);

      // Fixed points of both transforms.
      run_col("fix01_fwd", 32'h01010101, 1'b0, 32'h01010101, 1'b1, 0);
      run_col("fix01_inv", 32'h01010101, 1'b1, 32'h01010101, 1'b0, 0);
      run_col("fixc6_fwd", 32'hC6C6C6C6, 1'b0, 32'hC6C6C6C6, 1'b0, 0);
      run_col("fixc6_inv", 32'hC6C6C6C6, 1'b1, 32'hC6C6C6C6, 1'b1, 0);

      // 20-cycle stall in DONE with stray in_valid pulses.
      run_col("bp_f20a",   32'hF20A225C, 1'b0, 32'h9FDC589D, 1'b0, 20);

      // Abort at cnt = 7, then clear+in_valid together in IDLE must not accept.
      bus.in_valid = 1'b1;
      bus.col_in   = 32'h12345678;
      bus.inv      = 1'b0;
      @(negedge clk);                       // accepted at E0
      bus.in_valid = 1'b0;
      repeat (7) @(negedge clk);            // cnt = 7 now
      bus.clear = 1'b1;
      @(negedge clk);
      chk("clear_ctl", {29'd0, bus.out_valid, bus.busy, bus.in_ready}, 32'd1);
      chk("clear_col", bus.col_out, 32'h0);
      bus.in_valid = 1'b1;
      bus.col_in   = 32'hDEADBEEF;
      @(negedge clk);
      chk("clear_noacc", {30'd0, bus.busy, bus.in_ready}, 32'd1);
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      run_col("post_clear", 32'hDB135345, 1'b0, 32'h8E4DA1BC, 1'b0, 0);

      // Asynchronous reset while holding a result in DONE.
      bus.in_valid = 1'b1;
      bus.col_in   = 32'h9FDC589D;
      bus.inv      = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (16) @(negedge clk);
      chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_ctl", {29'd0, bus.out_valid, bus.busy, bus.in_ready}, 32'd1);
      chk("async_rst_col", bus.col_out, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_col("post_rst", 32'hDB135345, 1'b0, 32'h8E4DA1BC, 1'b1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
